// File: rtl/cxapbasyncbridge_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// cxapbasyncbridge_xfer_ctrl
//
// Source-side transfer controller of an asynchronous bridge. A local requester
// hands over one payload at a time; the controller launches it to the far clock
// domain with a registered four-phase request/acknowledge handshake and reports
// completion, progress and a sticky watchdog timeout.
//
// Ports
//   clk        in   sole clock, rising edge
//   resetn     in   synchronous active-low reset
//   src_valid  in   requester has a payload
//   src_data   in   payload (WIDTH bits), captured only on accept
//   src_ready  out  payload can be accepted this cycle (comb. from state/ack)
//   ack_sync   in   far-side acknowledge, already synchronized externally
//   sync_en    out  enable for the external ack synchronizer (= busy)
//   req_async  out  registered four-phase request
//   data_async out  registered payload, stable from accept to next accept
//   busy       out  handshake in progress
//   done       out  one-cycle completion pulse
//   timeout    out  sticky handshake-phase timeout flag
//   tmo_clr    in   clears timeout (a coincident set wins)
// -----------------------------------------------------------------------------
module cxapbasyncbridge_xfer_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  input  logic             ack_sync,
  output logic             sync_en,
  output logic             req_async,
  output logic [WIDTH-1:0] data_async,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  input  logic             tmo_clr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  localparam logic [7:0] TMO_VAL = 8'(TIMEOUT);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             accept_s;
  logic             ready_s;
  logic [7:0]       cnt_inc_s;
  logic             tmo_hit_s;

  // Handshake status decoded straight from the state register.
  always_comb begin
    ready_s   = (state_q == ST_IDLE) && !ack_sync;
    accept_s  = src_valid && ready_s;
    // Saturating increment of the phase counter.
    cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 8'd1);
  end

  // Next-state, request, payload, counter and flag logic.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    tmo_hit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An ack seen while idle blocks src_ready and has no other effect.
        if (accept_s) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          data_d  = src_data;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_sync) begin
          state_d = ST_REL;
          req_d   = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d     = cnt_inc_s;
          // Flag only when the counter actually steps onto the limit.
          tmo_hit_s = (cnt_q != CNT_MAX) && (cnt_inc_s == TMO_VAL);
        end
      end
      ST_REL: begin
        cnt_d     = cnt_inc_s;
        tmo_hit_s = (cnt_q != CNT_MAX) && (cnt_inc_s == TMO_VAL);
        if (!ack_sync) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_REL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase

    // Sticky timeout: a set on the same edge as a clear takes priority.
    if (tmo_hit_s) begin
      tmo_d = 1'b1;
    end else if (tmo_clr) begin
      tmo_d = 1'b0;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mapping; the synchronizer only runs while a handshake is open.
  always_comb begin
    src_ready  = ready_s;
    busy       = (state_q == ST_REQ) || (state_q == ST_REL);
    sync_en    = busy;
    req_async  = req_q;
    data_async = data_q;
    done       = done_q;
    timeout    = tmo_q;
  end

endmodule

// File: tb/tb_cxapbasyncbridge_xfer_ctrl.sv
module tb_cxapbasyncbridge_xfer_ctrl;

  localparam int W   = 32;
  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         src_valid;
  logic [W-1:0] src_data;
  logic         src_ready;
  logic         ack_sync;
  logic         sync_en;
  logic         req_async;
  logic [W-1:0] data_async;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         tmo_clr;

  always #5 clk = ~clk;

  cxapbasyncbridge_xfer_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .ack_sync(ack_sync), .sync_en(sync_en),
    .req_async(req_async), .data_async(data_async), .busy(busy), .done(done),
    .timeout(timeout), .tmo_clr(tmo_clr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: "request outstanding", "waiting for ack release",
  // payload held, done pulse, sticky timeout and phase age in cycles.
  bit           m_pend, m_wl, m_done, m_tmo;
  logic [W-1:0] m_data;
  int           m_age;
  logic [W-1:0] acc_q[$];
  logic [W-1:0] got_q[$];

  bit   auto_ack;
  int   dly, lag;
  logic prev_req;
  int   done_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from current inputs, clock, compare, run far side.
  task automatic step();
    bit n_pend, n_wl, n_done, n_tmo, idle, set_t;
    logic [W-1:0] n_data;
    int n_age;
    idle   = !m_pend && !m_wl;
    n_pend = m_pend; n_wl = m_wl; n_data = m_data; n_age = m_age;
    n_done = 1'b0; n_tmo = m_tmo; set_t = 1'b0;
    if (!resetn) begin
      n_pend = 1'b0; n_wl = 1'b0; n_data = '0; n_age = 0; n_tmo = 1'b0;
    end else begin
      n_done = m_wl && !ack_sync;
      if (idle && !ack_sync && src_valid) begin
        n_pend = 1'b1; n_data = src_data; n_age = 0;
        acc_q.push_back(src_data);
      end else if (m_pend && ack_sync) begin
        n_pend = 1'b0; n_wl = 1'b1; n_age = 0;
      end else if (!idle) begin
        if (m_age < 255) begin
          n_age = m_age + 1;
          set_t = (n_age == TMO);
        end
        if (m_wl && !ack_sync) n_wl = 1'b0;
      end
      n_tmo = set_t ? 1'b1 : (tmo_clr ? 1'b0 : m_tmo);
    end
    @(posedge clk); #1;
    m_pend = n_pend; m_wl = n_wl; m_data = n_data; m_age = n_age;
    m_done = n_done; m_tmo = n_tmo;
    chk("req_async",  64'(req_async),  64'(m_pend));
    chk("data_async", 64'(data_async), 64'(m_data));
    chk("busy",       64'(busy),       64'(m_pend || m_wl));
    chk("sync_en",    64'(sync_en),    64'(m_pend || m_wl));
    chk("done",       64'(done),       64'(m_done));
    chk("timeout",    64'(timeout),    64'(m_tmo));
    chk("src_ready",  64'(src_ready),  64'(!m_pend && !m_wl && !ack_sync));
    if (done) done_cnt++;
    if (req_async && !prev_req) got_q.push_back(data_async);
    prev_req = req_async;
    if (auto_ack) begin
      if (ack_sync != req_async) begin
        lag++;
        if (lag >= dly) begin
          ack_sync = req_async;
          lag = 0;
        end
      end else begin
        lag = 0;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int acc_before;
    resetn = 1'b0; src_valid = 1'b0; src_data = '0; ack_sync = 1'b0; tmo_clr = 1'b0;
    m_pend = 0; m_wl = 0; m_done = 0; m_tmo = 0; m_data = '0; m_age = 0;
    auto_ack = 1'b0; dly = 1; lag = 0; prev_req = 1'b0; done_cnt = 0;

    // Reset, then first cycle after release.
    steps(2);
    chk("rst_req", 64'(req_async), 64'd0);
    chk("rst_data", 64'(data_async), 64'd0);
    resetn = 1'b1;
    step();
    chk("post_rst_ready", 64'(src_ready), 64'd1);

    // Basic transfer with 3-cycle far-side latency.
    auto_ack = 1'b1; dly = 3; done_cnt = 0;
    src_valid = 1'b1; src_data = 32'hA5A5_0001;
    step();
    src_valid = 1'b0; src_data = 32'h0;
    steps(16);
    chk("basic_data", 64'(data_async), 64'hA5A5_0001);
    chk("basic_done_pulses", 64'(done_cnt), 64'd1);
    tmo_clr = 1'b1; step(); tmo_clr = 1'b0;

    // Back-to-back with 1-cycle far side.
    dly = 1; acc_before = acc_q.size();
    src_valid = 1'b1; src_data = 32'h1111_2222;
    for (int i = 0; i < 30 && acc_q.size() < acc_before + 2; i++) begin
      step();
      if (acc_q.size() == acc_before + 1) begin
        src_data = 32'h3333_4444;
        if (m_done) chk("b2b_in_done_cycle", 64'(src_ready), 64'd1);
      end
    end
    src_valid = 1'b0;
    chk("b2b_accepts", 64'(acc_q.size()), 64'(acc_before + 2));
    steps(8);

    // Timeout with ack held low, then late completion and clear.
    auto_ack = 1'b0; ack_sync = 1'b0;
    src_valid = 1'b1; src_data = 32'hDEAD_BEEF;
    step();
    src_valid = 1'b0;
    steps(3);
    chk("tmo_not_yet", 64'(timeout), 64'd0);
    step();
    chk("tmo_at_limit", 64'(timeout), 64'd1);
    chk("tmo_still_req", 64'(req_async), 64'd1);
    steps(3);
    tmo_clr = 1'b1; step(); tmo_clr = 1'b0;
    chk("tmo_cleared", 64'(timeout), 64'd0);
    ack_sync = 1'b1; steps(2);
    ack_sync = 1'b0; steps(2);
    chk("tmo_late_data", 64'(data_async), 64'hDEAD_BEEF);

    // Set/clear collision: clear held across the setting edge.
    tmo_clr = 1'b1;
    src_valid = 1'b1; src_data = 32'h0BAD_F00D;
    step();
    src_valid = 1'b0;
    steps(4);
    chk("tmo_set_wins", 64'(timeout), 64'd1);
    step();
    chk("tmo_clr_after", 64'(timeout), 64'd0);
    tmo_clr = 1'b0;
    ack_sync = 1'b1; steps(2); ack_sync = 1'b0; steps(2);

    // Reset in the release phase.
    ack_sync = 1'b0;
    src_valid = 1'b1; src_data = 32'h5A5A_7777;
    step();
    src_valid = 1'b0;
    ack_sync = 1'b1; step();
    chk("rel_phase", 64'(busy && !req_async), 64'd1);
    done_cnt = 0;
    resetn = 1'b0; step();
    chk("midrst_data", 64'(data_async), 64'd0);
    resetn = 1'b1; ack_sync = 1'b0; steps(2);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_ready", 64'(src_ready), 64'd1);

    // Spurious ack while idle blocks acceptance until it drops.
    acc_before = acc_q.size();
    ack_sync = 1'b1; src_valid = 1'b1; src_data = 32'hC0DE_0042;
    steps(3);
    chk("spur_no_accept", 64'(acc_q.size()), 64'(acc_before));
    ack_sync = 1'b0; step();
    src_valid = 1'b0;
    chk("spur_accept", 64'(data_async), 64'hC0DE_0042);
    ack_sync = 1'b1; steps(2); ack_sync = 1'b0; steps(2);

    // Randomized traffic with a variable-latency far side.
    auto_ack = 1'b1; lag = 0;
    for (int i = 0; i < 600; i++) begin
      src_valid = 1'($urandom_range(0, 1));
      src_data  = $urandom;
      tmo_clr   = ($urandom_range(0, 7) == 0);
      resetn    = ($urandom_range(0, 149) != 0);
      if (!busy) dly = $urandom_range(1, 6);
      step();
    end
    resetn = 1'b1; src_valid = 1'b0; tmo_clr = 1'b0;
    steps(20);

    // Far-side view of launched payloads versus model accepts.
    chk("n_launched", 64'(got_q.size()), 64'(acc_q.size()));
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++)
      chk("launched_payload", 64'(got_q[i]), 64'(acc_q[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
